// File: rtl/serial_slice_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_slice_adder
// Brief    : Multi-cycle wide adder. It processes one 8-bit slice per clock,
//            LSB slice first. Each slice uses a 2-bit propagate/generate
//            group carry generator. Each slice's carry-out becomes the carry
//            into the next slice. The module reports sum and carry-out with
//            a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_slice_adder #(
  parameter int NUM_SLICES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*NUM_SLICES-1:0] a_in,
  input  logic [8*NUM_SLICES-1:0] b_in,
  input  logic                    c_in,
  output logic                    busy,
  output logic                    done,
  output logic [8*NUM_SLICES-1:0] sum,
  output logic                    c_out
);

  localparam int W     = 8 * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Slice datapath signals
  logic [7:0] w_sa, w_sb, w_p, w_g, w_cin, w_ssum;
  logic [3:0] w_gen_co;

  // Group carry generator for the current slice. Bit pairs form P/G groups.
  // The CARRY4 style mux selects the carry in when the group propagates and
  // the group generate otherwise. Odd-bit carries are then formed locally.
  always_comb begin
    logic c;
    logic grp_p, grp_g;
    w_sa     = a_q[8*idx_q +: 8];
    w_sb     = b_q[8*idx_q +: 8];
    w_p      = w_sa ^ w_sb;
    w_g      = w_sa & w_sb;
    w_gen_co = '0;
    c        = carry_q;
    for (int k = 0; k < 4; k++) begin
      grp_p       = w_p[2*k] & w_p[2*k+1];
      grp_g       = w_g[2*k+1] | (w_p[2*k+1] & w_g[2*k]);
      c           = grp_p ? c : grp_g;
      w_gen_co[k] = c;
    end
    w_cin[0] = carry_q;
    for (int k = 0; k < 4; k++) begin
      w_cin[2*k+1] = w_g[2*k] | (w_p[2*k] & w_cin[2*k]);
      if (k < 3) begin
        w_cin[2*k+2] = w_gen_co[k];
      end
    end
    w_ssum = w_p ^ w_cin;
  end

  // Next-state logic, operand latching and slice write-back
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy                 = 1'b1;
        sum_d[8*idx_q +: 8]  = w_ssum;
        carry_d              = w_gen_co[3];
        idx_d                = idx_q + 1'b1;
        if (idx_q == C_LAST_IDX) begin
          cout_d  = w_gen_co[3];
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_slice_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_slice_adder
// Brief    : Self-checking bench for serial_slice_adder (NUM_SLICES = 4).
//            It uses a scoreboard of expected {c_out, sum} values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_slice_adder;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         c_in;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  logic [W:0] exp_q[$];

  serial_slice_adder #(.NUM_SLICES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // This task is called at #1 after an edge with the DUT idle. It pushes the
  // expected result and holds start for one edge. It then scrambles the
  // inputs so that any dependence on unlatched operands becomes visible.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] e;
    a_in  = a;
    b_in  = b;
    c_in  = ci;
    start = 1'b1;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    c_in  = $urandom_range(0, 1);
  endtask

  // This task waits up to 40 edges for done. It returns whether done was
  // seen, how many edges that took, and how many sampled cycles had busy high.
  task automatic wait_done(output bit got, output int cyc, output int bcnt);
    got  = 1'b0;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, c_out, sum} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b c_out=%b sum=%h, required all 0", busy, done, c_out, sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [W-1:0] va[5] = '{32'hFFFFFFFF, 32'h12345678, 32'h7FFFFFFF, 32'h55555555, 32'hFFFFFFFF};
    logic [W-1:0] vb[5] = '{32'h00000001, 32'h9ABCDEF0, 32'h00000000, 32'h55555555, 32'hFFFFFFFF};
    logic         vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W:0]   req[5] = '{33'h1_00000000, 33'h0_ACF13568, 33'h0_80000000, 33'h0_AAAAAAAA, 33'h1_FFFFFFFF};
    bit got; int cyc, bcnt;
    logic [W:0] e;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_done(got, cyc, bcnt);
      e = exp_q.pop_front();
      checks++;
      if (!got || {c_out, sum} !== req[i] || e !== req[i]) begin
        failures++;
        $display("FAIL basic_%0d: got_done=%0b {c_out,sum}=%h, required %h", i, got, {c_out, sum}, req[i]);
      end
      if (i == 0) begin
        checks++;
        if (cyc != N || bcnt != N) begin
          failures++;
          $display("FAIL latency_busy: done after %0d edges busy %0d cycles, required %0d and %0d", cyc, bcnt, N, N);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start;
    bit got; int cyc, bcnt;
    logic [W:0] e, held;
    issue(32'h0F0F0F0F, 32'h01010101, 1'b1);
    @(posedge clk); #1;
    // This start pulse arrives two cycles into RUN, so the DUT must ignore it.
    a_in = 32'hDEADBEEF; b_in = 32'hCAFEF00D; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(got, cyc, bcnt);
    e = exp_q.pop_front();
    checks++;
    if (!got || {c_out, sum} !== e || cyc != N - 2) begin
      failures++;
      $display("FAIL ignore_run_start: got_done=%0b edges=%0d {c_out,sum}=%h, required done after %0d edges with %h", got, cyc, {c_out, sum}, N - 2, e);
    end
    held = {c_out, sum};
    // A start raised during DONE must also be ignored.
    a_in = 32'h11111111; b_in = 32'h22222222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {c_out, sum} !== held) begin
      failures++;
      $display("FAIL hold_idle: busy=%b done=%b {c_out,sum}=%h, required idle holding %h", busy, done, {c_out, sum}, held);
    end
  endtask

  task automatic test_async_reset;
    bit got; int cyc, bcnt;
    logic [W:0] e;
    issue(32'h11111111, 32'h22222222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // This is the third RUN cycle. Assert reset away from any clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, c_out, sum} !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b c_out=%b sum=%h, required all 0", busy, done, c_out, sum);
    end
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(got, cyc, bcnt);
    checks++;
    if (got || busy !== 1'b0) begin
      failures++;
      $display("FAIL no_done_after_reset: done_seen=%0b busy=%b, required 0 and 0", got, busy);
    end
    issue(32'h00000001, 32'h00000001, 1'b0);
    wait_done(got, cyc, bcnt);
    e = exp_q.pop_front();
    checks++;
    if (!got || {c_out, sum} !== 33'h0_00000002 || e !== 33'h0_00000002) begin
      failures++;
      $display("FAIL post_reset_add: got_done=%0b {c_out,sum}=%h, required 000000002", got, {c_out, sum});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bit got; int cyc, bcnt;
    int last_done, bad_val, bad_gap;
    logic [W:0] e;
    last_done = -1; bad_val = 0; bad_gap = 0;
    for (int i = 0; i < 10000; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done(got, cyc, bcnt);
      e = exp_q.pop_front();
      checks++;
      if (!got || {c_out, sum} !== e) begin
        failures++;
        if (bad_val < 5) $display("FAIL rand_%0d: got_done=%0b {c_out,sum}=%h, required %h", i, got, {c_out, sum}, e);
        bad_val++;
      end
      if (last_done >= 0) begin
        checks++;
        if (cyc_cnt - last_done != N + 2) begin
          failures++;
          if (bad_gap < 5) $display("FAIL done_spacing_%0d: %0d cycles, required %0d", i, cyc_cnt - last_done, N + 2);
          bad_gap++;
        end
      end
      last_done = cyc_cnt;
      if (!got) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
